// File: rtl/inv_stage.sv
// Ring-oscillator inverter stage with a clocked activity monitor that counts
// synchronised rising edges of Q per fixed window of clk cycles.
module inv_stage #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned WINDOW      = 1024,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  (* keep *) input  logic  A,
  (* keep *) output logic  Q,
  input  logic             mon_en,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             active,
  output logic             saturated
);

  localparam int unsigned       WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  // The oscillator path: a single inverter, never touched by the monitor.
  assign Q = ~A;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_q_prev;
  logic [WIN_W-1:0]       r_win_cnt;
  logic [CNT_W-1:0]       r_acc;
  logic [CNT_W-1:0]       r_count;
  logic                   r_count_valid;
  logic                   r_active;
  logic                   r_saturated;

  logic                   w_q_s;
  logic                   w_rise;
  logic                   w_win_end;
  logic [CNT_W:0]         w_sum;
  logic [CNT_W-1:0]       w_sum_sat;

  assign w_q_s     = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_q_s & ~r_q_prev;
  assign w_win_end = mon_en && (r_win_cnt == WIN_LAST);

  // Accumulator already saturates, so the sum can exceed the max by at most one.
  always_comb begin
    w_sum     = {1'b0, r_acc} + (CNT_W + 1)'(w_rise);
    w_sum_sat = w_sum[CNT_W] ? CNT_MAX : w_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_q_prev <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], Q};
      r_q_prev <= w_q_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_cnt <= '0;
      r_acc     <= '0;
    end else if (!mon_en || w_win_end) begin
      r_win_cnt <= '0;
      r_acc     <= '0;
    end else begin
      r_win_cnt <= r_win_cnt + WIN_W'(1);
      r_acc     <= w_sum_sat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count       <= '0;
      r_count_valid <= 1'b0;
      r_active      <= 1'b0;
      r_saturated   <= 1'b0;
    end else if (w_win_end) begin
      r_count       <= w_sum_sat;
      r_count_valid <= 1'b1;
      r_active      <= (w_sum_sat != '0);
      r_saturated   <= (w_sum_sat == CNT_MAX);
    end else begin
      r_count_valid <= 1'b0;
    end
  end

  assign count       = r_count;
  assign count_valid = r_count_valid;
  assign active      = r_active;
  assign saturated   = r_saturated;

endmodule

// File: tb/tb_inv_stage.sv
// Directed bench for inv_stage: one 16-bit/WINDOW=8 instance and one
// 2-bit/WINDOW=16 instance for saturation.
module tb_inv_stage;

  logic        clk;
  logic        rst_n;
  logic        a1, a2;
  logic        q1, q2;
  logic        en1, en2;
  logic [15:0] cnt1;
  logic [1:0]  cnt2;
  logic        v1, v2;
  logic        act1, act2;
  logic        sat1, sat2;

  int checks = 0;
  int errors = 0;

  inv_stage #(.CNT_W(16), .WINDOW(8), .SYNC_STAGES(2)) u_dut_w8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .A           (a1),
    .Q           (q1),
    .mon_en      (en1),
    .count       (cnt1),
    .count_valid (v1),
    .active      (act1),
    .saturated   (sat1)
  );

  inv_stage #(.CNT_W(2), .WINDOW(16), .SYNC_STAGES(2)) u_dut_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .A           (a2),
    .Q           (q2),
    .mon_en      (en2),
    .count       (cnt2),
    .count_valid (v2),
    .active      (act2),
    .saturated   (sat2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Enables the selected DUT and plays qpat (bit n = Q level at negedge n);
  // returns the negedge index at which count_valid was seen, -1 on timeout.
  task automatic drive_window(input int which, input logic [31:0] qpat, input int maxc,
                              output int cycles);
    cycles = -1;
    if (which == 1) begin en1 = 1'b1; a1 = ~qpat[0]; end
    else            begin en2 = 1'b1; a2 = ~qpat[0]; end
    for (int n = 1; n <= maxc; n++) begin
      @(negedge clk);
      if ((which == 1 && v1) || (which == 2 && v2)) begin
        cycles = n;
        break;
      end
      if (which == 1) a1 = (n < 32) ? ~qpat[n] : 1'b1;
      else            a2 = (n < 32) ? ~qpat[n] : 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en1 = 1'b0; en2 = 1'b0;
    a1 = 1'b0; a2 = 1'b0;
    #1;
    checks++; if (q1 !== 1'b1) begin errors++; $display("FAIL inv_a0_q1 got %b want 1", q1); end
    checks++; if (q2 !== 1'b1) begin errors++; $display("FAIL inv_a0_q2 got %b want 1", q2); end
    a1 = 1'b1; a2 = 1'b1;
    #1;
    checks++; if (q1 !== 1'b0) begin errors++; $display("FAIL inv_a1_q1 got %b want 0", q1); end
    checks++; if (q2 !== 1'b0) begin errors++; $display("FAIL inv_a1_q2 got %b want 0", q2); end
    idle(2);
    checks++; if (cnt1 !== 16'd0) begin errors++; $display("FAIL rst_count got %0d want 0", cnt1); end
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", v1); end
    checks++; if (act1 !== 1'b0) begin errors++; $display("FAIL rst_active got %b want 0", act1); end
    checks++; if (sat1 !== 1'b0) begin errors++; $display("FAIL rst_sat got %b want 0", sat1); end
    checks++; if (cnt2 !== 2'd0) begin errors++; $display("FAIL rst_count2 got %0d want 0", cnt2); end
    checks++; if (sat2 !== 1'b0) begin errors++; $display("FAIL rst_sat2 got %b want 0", sat2); end
    rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_static;
    int c;
    drive_window(1, 32'h0, 20, c);
    checks++; if (c !== 8) begin errors++; $display("FAIL static_latency got %0d want 8", c); end
    checks++; if (cnt1 !== 16'd0) begin errors++; $display("FAIL static_count got %0d want 0", cnt1); end
    checks++; if (act1 !== 1'b0) begin errors++; $display("FAIL static_active got %b want 0", act1); end
    checks++; if (sat1 !== 1'b0) begin errors++; $display("FAIL static_sat got %b want 0", sat1); end
    drive_window(1, 32'h0, 20, c);
    checks++; if (c !== 8) begin errors++; $display("FAIL static_repeat got %0d want 8", c); end
    checks++; if (cnt1 !== 16'd0) begin errors++; $display("FAIL static_count2 got %0d want 0", cnt1); end
    en1 = 1'b0;
    @(negedge clk);
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL static_pulse got %b want 0", v1); end
    idle(3);
  endtask

  task automatic test_three_edges;
    int c;
    drive_window(1, 32'h15, 20, c);
    checks++; if (c !== 8) begin errors++; $display("FAIL three_latency got %0d want 8", c); end
    checks++; if (cnt1 !== 16'd3) begin errors++; $display("FAIL three_count got %0d want 3", cnt1); end
    checks++; if (act1 !== 1'b1) begin errors++; $display("FAIL three_active got %b want 1", act1); end
    checks++; if (sat1 !== 1'b0) begin errors++; $display("FAIL three_sat got %b want 0", sat1); end
    en1 = 1'b0;
    @(negedge clk);
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL three_pulse got %b want 0", v1); end
    checks++; if (cnt1 !== 16'd3) begin errors++; $display("FAIL three_hold got %0d want 3", cnt1); end
    idle(3);
  endtask

  task automatic test_drop;
    logic [31:0] pat;
    logic        seen;
    int          c;
    pat  = 32'h5;
    seen = 1'b0;
    en1  = 1'b1;
    a1   = ~pat[0];
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      seen = seen | v1;
      a1 = ~pat[n];
    end
    en1 = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      seen = seen | v1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL drop_no_valid got %b want 0", seen); end
    checks++; if (cnt1 !== 16'd3) begin errors++; $display("FAIL drop_count got %0d want 3", cnt1); end
    checks++; if (act1 !== 1'b1) begin errors++; $display("FAIL drop_active got %b want 1", act1); end
    drive_window(1, 32'h0, 20, c);
    checks++; if (c !== 8) begin errors++; $display("FAIL drop_restart got %0d want 8", c); end
    checks++; if (cnt1 !== 16'd0) begin errors++; $display("FAIL drop_new_count got %0d want 0", cnt1); end
    checks++; if (act1 !== 1'b0) begin errors++; $display("FAIL drop_new_active got %b want 0", act1); end
    en1 = 1'b0;
    idle(3);
  endtask

  task automatic test_saturate;
    int c;
    // Q high two cycles, low two: four rises land inside the 16-cycle window.
    drive_window(2, 32'h33333333, 40, c);
    checks++; if (c !== 16) begin errors++; $display("FAIL sat_latency got %0d want 16", c); end
    checks++; if (cnt2 !== 2'd3) begin errors++; $display("FAIL sat_count got %0d want 3", cnt2); end
    checks++; if (sat2 !== 1'b1) begin errors++; $display("FAIL sat_flag got %b want 1", sat2); end
    checks++; if (act2 !== 1'b1) begin errors++; $display("FAIL sat_active got %b want 1", act2); end
    en2 = 1'b0;
    a2  = 1'b1;
    idle(3);
  endtask

  task automatic test_reset_mid;
    int c;
    drive_window(1, 32'h15, 20, c);
    checks++; if (cnt1 !== 16'd3) begin errors++; $display("FAIL rmid_pre got %0d want 3", cnt1); end
    idle(3);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (cnt1 !== 16'd0) begin errors++; $display("FAIL rmid_count got %0d want 0", cnt1); end
    checks++; if (act1 !== 1'b0) begin errors++; $display("FAIL rmid_active got %b want 0", act1); end
    a1 = 1'b0;
    #1;
    checks++; if (q1 !== 1'b1) begin errors++; $display("FAIL rmid_q_hi got %b want 1", q1); end
    a1 = 1'b1;
    #1;
    checks++; if (q1 !== 1'b0) begin errors++; $display("FAIL rmid_q_lo got %b want 0", q1); end
    en1 = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
  endtask

  initial begin
    test_reset();
    test_static();
    test_three_edges();
    test_drop();
    test_saturate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
